hamming_serial_rx: RTL and testbench
====================================

Name: hamming_serial_rx

Overview:
- Receive-side endpoint for Hamming(7,4) codewords that arrive one bit per beat on a serial link.
- Deserializes each 7-bit codeword, computes the syndrome under even or odd parity, and corrects any single-bit error.
- Presents the decoded nibble, the corrected codeword and error information on a valid/ready output.
- Sits after the serial transmit side of the Hamming encoder; it is the receiving end of that link.

Parameters:
- CNT_W, 8, width of the saturating corrected-error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- parity_type  in  1  0 = even parity, 1 = odd parity; sampled on the SOF beat and held for the frame.
- sin_valid  in  1  serial beat valid.
- sin_sof  in  1  marks the first bit (position 1) of a codeword.
- sin_bit  in  1  serial code bit; order is position 1 first, position 7 last.
- sin_ready  out  1  block accepts a serial beat this cycle.
- dout_valid  out  1  decoded result available.
- dout_ready  in  1  downstream accepts the result.
- data_out  out  4 [4:1]  decoded data: d1=pos3, d2=pos5, d3=pos6, d4=pos7.
- corrected_code  out  7 [7:1]  codeword after correction.
- error_pos  out  3 [2:0]  syndrome; 0 means no error, otherwise the flipped bit position.
- error_d  out  1  single-bit error detected and corrected.
- frame_err  out  1  one-cycle pulse when a frame is aborted by an early SOF.
- cnt_clr  in  1  synchronous clear of err_count.
- err_count  out  CNT_W  count of accepted results with error_d=1.

Behaviour:
- Reset (asynchronous): state IDLE, shift register 0, bit count 0. All outputs 0 except sin_ready=1.
- Beat acceptance: a beat is accepted when sin_valid & sin_ready.
- IDLE (sin_ready=1):
  - Accepted beat with sin_sof: store the bit as pos1, latch parity_type, go to SHIFT with bit count 1.
  - Accepted beat without sin_sof: dropped, no flag.
- SHIFT (sin_ready=1):
  - Accepted beat without SOF stores the bit at position count+1.
  - After pos7 is stored, go to DECODE.
  - Accepted beat with SOF: restart the frame with this bit as pos1, re-latch parity_type, pulse frame_err for one cycle.
  - Cycles with sin_valid=0 hold state; there is no timeout.
- Syndrome rule:
  - c1 = xor of positions 1,3,5,7; c2 = xor of positions 2,3,6,7; c3 = xor of positions 4,5,6,7.
  - Each check bit is inverted when the latched parity_type=1.
  - Syndrome s = {c3,c2,c1}.
- DECODE (sin_ready=0), one cycle:
  - Register corrected_code = code with bit s flipped when s≠0.
  - Register data_out from corrected_code, error_pos = s, error_d = (s≠0).
  - Go to OUT.
- OUT (sin_ready=0):
  - dout_valid=1; all result outputs are stable until handshake.
  - On dout_ready, return to IDLE; dout_valid falls the next cycle.
- Latency: pos7 accepted at cycle N → dout_valid=1 at cycle N+2. Best-case throughput is one codeword per 9 cycles.
- Result outputs hold their last values after the handshake until the next DECODE.
- Double-bit errors are not detected; they are treated as single-bit errors (known Hamming(7,4) limitation).
- err_count:
  - Increments when dout_valid & dout_ready & error_d.
  - Saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle.
- Reset mid-frame or mid-OUT: the partial frame or pending result is discarded with no output.
- A parity_type change mid-frame has no effect on the frame in progress.

Decomposition:
- Shared package hamming_pkg:
  - state encoding (IDLE/SHIFT/DECODE/OUT);
  - position constants for p1/p2/d1/p3/d2/d3/d4;
  - a syndrome function, reused by the encoder-side checker.
- One sub-module, hamming_syndrome_correct: combinational; inputs code[7:1] and parity_type; outputs corrected_code, data_out, error_pos, error_d. Instantiated in DECODE.
- FSM, shift register and counter stay in hamming_serial_rx.

Test Plan:
- Clean frame, even parity: send code 7'b0101101 → data_out=0101, error_d=0, error_pos=000, err_count=0. dout_valid rises 2 cycles after the pos7 beat.
- Single error, even parity: send 7'b0111101 (pos5 flipped) → error_pos=101, corrected_code=0101101, data_out=0101, error_d=1. err_count=1 after handshake.
- Odd parity: parity_type=1, send 7'b0001011 → data_out=0000, error_d=0. Flip pos2 (send 0001001) → error_pos=010, data_out=0000.
- Abort: SOF plus 3 bits, then SOF starting full frame 7'b0101101 → frame_err pulses exactly one cycle; result data_out=0101, no error.
- Backpressure and stray input: hold dout_ready=0 for 5 cycles with sin_valid=1 → outputs stable, sin_ready=0, no beats accepted. Separately, a non-SOF beat in IDLE is dropped.
- Counter and reset, with CNT_W=2:
  - four errored frames → err_count=3 (saturated);
  - cnt_clr together with a fifth errored handshake → 0;
  - rst asserted after 4 bits → state IDLE, sin_ready=1, no dout_valid.

Source files
------------

// File: rtl/hamming_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hamming_pkg                                            |
// | Description : Shared Hamming(7,4) definitions: receiver state        |
// |               encoding, codeword bit positions, syndrome function.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package hamming_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2,
    ST_OUT    = 2'd3
  } rx_state_t;

  // Codeword positions (1-based, position 1 travels first on the link)
  localparam int C_POS_P1 = 1;
  localparam int C_POS_P2 = 2;
  localparam int C_POS_D1 = 3;
  localparam int C_POS_P3 = 4;
  localparam int C_POS_D2 = 5;
  localparam int C_POS_D3 = 6;
  localparam int C_POS_D4 = 7;

  // Syndrome {c3,c2,c1}; odd parity inverts every check bit
  function automatic logic [2:0] hamming_syndrome(input logic [7:1] code,
                                                  input logic       parity_type);
    logic c1, c2, c3;
    c1 = code[C_POS_P1] ^ code[C_POS_D1] ^ code[C_POS_D2] ^ code[C_POS_D4] ^ parity_type;
    c2 = code[C_POS_P2] ^ code[C_POS_D1] ^ code[C_POS_D3] ^ code[C_POS_D4] ^ parity_type;
    c3 = code[C_POS_P3] ^ code[C_POS_D2] ^ code[C_POS_D3] ^ code[C_POS_D4] ^ parity_type;
    return {c3, c2, c1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_syndrome_correct.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hamming_syndrome_correct                               |
// | Description : Combinational syndrome evaluation and single-bit       |
// |               correction of a Hamming(7,4) codeword.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hamming_syndrome_correct
  import hamming_pkg::*;
(
  input  logic [7:1] code,
  input  logic       parity_type,
  output logic [7:1] corrected_code,
  output logic [4:1] data_out,
  output logic [2:0] error_pos,
  output logic       error_d
);

  logic [7:0] w_flip;

  // A one-hot mask built from the syndrome; syndrome 0 lands on bit 0,
  // which is outside the codeword, so a clean word passes untouched.
  always_comb begin
    error_pos      = hamming_syndrome(code, parity_type);
    error_d        = (error_pos != 3'd0);
    w_flip         = 8'd1 << error_pos;
    corrected_code = code ^ w_flip[7:1];
    data_out       = {corrected_code[C_POS_D4], corrected_code[C_POS_D3],
                      corrected_code[C_POS_D2], corrected_code[C_POS_D1]};
  end

endmodule
`default_nettype wire

// File: rtl/hamming_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hamming_serial_rx                                      |
// | Description : Serial Hamming(7,4) receiver: deserializes codewords,  |
// |               corrects single-bit errors, presents results on a      |
// |               valid/ready port and counts corrected errors.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parity_type,
  input  logic             sin_valid,
  input  logic             sin_sof,
  input  logic             sin_bit,
  output logic             sin_ready,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [4:1]       data_out,
  output logic [7:1]       corrected_code,
  output logic [2:0]       error_pos,
  output logic             error_d,
  output logic             frame_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [7:1]       r_code;
  logic [2:0]       r_bit_cnt;
  logic             r_parity;
  logic [7:1]       r_corrected;
  logic [4:1]       r_data;
  logic [2:0]       r_err_pos;
  logic             r_err_d;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_err_count;
  logic             w_accept;
  logic             w_handshake;
  logic [7:1]       w_dec_code;
  logic [4:1]       w_dec_data;
  logic [2:0]       w_dec_pos;
  logic             w_dec_err;

  assign sin_ready      = (r_state == ST_IDLE) || (r_state == ST_SHIFT);
  assign dout_valid     = (r_state == ST_OUT);
  assign w_accept       = sin_valid & sin_ready;
  assign w_handshake    = dout_valid & dout_ready;
  assign data_out       = r_data;
  assign corrected_code = r_corrected;
  assign error_pos      = r_err_pos;
  assign error_d        = r_err_d;
  assign frame_err      = r_frame_err;
  assign err_count      = r_err_count;

  hamming_syndrome_correct u_syndrome_correct (
    .code           (r_code),
    .parity_type    (r_parity),
    .corrected_code (w_dec_code),
    .data_out       (w_dec_data),
    .error_pos      (w_dec_pos),
    .error_d        (w_dec_err)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; IDLE and SHIFT are always ready, so sin_valid alone
  // qualifies a beat there
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (sin_valid && sin_sof) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (sin_valid && !sin_sof && r_bit_cnt == 3'd6) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = ST_OUT;
      ST_OUT:    if (dout_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame capture: SOF always restarts at position 1; an SOF while a frame
  // is in progress is an abort and raises a one-cycle frame_err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code      <= '0;
      r_bit_cnt   <= '0;
      r_parity    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_accept && sin_sof) begin
        r_code      <= {6'd0, sin_bit};
        r_bit_cnt   <= 3'd1;
        r_parity    <= parity_type;
        r_frame_err <= (r_state == ST_SHIFT);
      end else if (w_accept && r_state == ST_SHIFT) begin
        for (int i = 2; i <= 7; i++) begin
          if (i == int'(r_bit_cnt) + 1) r_code[i] <= sin_bit;
        end
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  // Result registers load once per frame and hold until the next decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corrected <= '0;
      r_data      <= '0;
      r_err_pos   <= '0;
      r_err_d     <= 1'b0;
    end else if (r_state == ST_DECODE) begin
      r_corrected <= w_dec_code;
      r_data      <= w_dec_data;
      r_err_pos   <= w_dec_pos;
      r_err_d     <= w_dec_err;
    end
  end

  // Saturating count of delivered corrected results; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (cnt_clr) begin
      r_err_count <= '0;
    end else if (w_handshake && r_err_d && r_err_count != {CNT_W{1'b1}}) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_hamming_serial_rx                                   |
// | Description : Self-checking bench for hamming_serial_rx with a       |
// |               behavioural Hamming(7,4) reference model.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_hamming_serial_rx;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             parity_type;
  logic             sin_valid;
  logic             sin_sof;
  logic             sin_bit;
  logic             sin_ready;
  logic             dout_valid;
  logic             dout_ready;
  logic [4:1]       data_out;
  logic [7:1]       corrected_code;
  logic [2:0]       error_pos;
  logic             error_d;
  logic             frame_err;
  logic             cnt_clr;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt    = 0;
  int fe_cnt   = 0;

  hamming_serial_rx #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .parity_type    (parity_type),
    .sin_valid      (sin_valid),
    .sin_sof        (sin_sof),
    .sin_bit        (sin_bit),
    .sin_ready      (sin_ready),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .data_out       (data_out),
    .corrected_code (corrected_code),
    .error_pos      (error_pos),
    .error_d        (error_d),
    .frame_err      (frame_err),
    .cnt_clr        (cnt_clr),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  // Count every cycle in which frame_err is high
  always @(negedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

  // Reference syndrome: XOR of the positions of all set bits, inverted for odd parity
  function automatic logic [2:0] ref_syn(input logic [7:1] c, input logic par);
    int s;
    s = 0;
    for (int p = 1; p <= 7; p++) if (c[p]) s = s ^ p;
    if (par) s = s ^ 7;
    return 3'(s);
  endfunction

  task automatic drive_beat(input logic b, input logic sof);
    sin_valid = 1'b1; sin_sof = sof; sin_bit = b;
    @(posedge clk);
    @(negedge clk);
    sin_valid = 1'b0; sin_sof = 1'b0; sin_bit = 1'b0;
  endtask

  task automatic send_code(input logic [7:1] code, input logic par);
    for (int p = 1; p <= 7; p++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (p == 1) parity_type = par;
      else        parity_type = 1'($urandom);
      drive_beat(code[p], p == 1);
    end
  endtask

  // Entered at the negedge right after the pos7 beat was accepted
  task automatic expect_result(input logic [7:1] code, input logic par, input int hold,
                               input logic clr_hs, input string name);
    logic [2:0] s;
    logic [7:1] cc;
    logic [4:1] d;
    logic       ed;
    s  = ref_syn(code, par);
    cc = code;
    if (s != 3'd0) cc[int'(s)] = ~cc[int'(s)];
    d  = {cc[7], cc[6], cc[5], cc[3]};
    ed = (s != 3'd0);
    n_checks++; if (dout_valid !== 1'b0) begin n_errors++; $display("FAIL %s early_valid got %b exp 0", name, dout_valid); end
    @(negedge clk);
    n_checks++; if (dout_valid !== 1'b1) begin n_errors++; $display("FAIL %s latency got %b exp 1", name, dout_valid); end
    n_checks++; if (data_out !== d) begin n_errors++; $display("FAIL %s data_out got %b exp %b", name, data_out, d); end
    n_checks++; if (corrected_code !== cc) begin n_errors++; $display("FAIL %s corrected got %b exp %b", name, corrected_code, cc); end
    n_checks++; if (error_pos !== s) begin n_errors++; $display("FAIL %s error_pos got %b exp %b", name, error_pos, s); end
    n_checks++; if (error_d !== ed) begin n_errors++; $display("FAIL %s error_d got %b exp %b", name, error_d, ed); end
    for (int i = 0; i < hold; i++) begin
      dout_ready = 1'b0; sin_valid = 1'b1; sin_sof = 1'($urandom); sin_bit = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b1 || sin_ready !== 1'b0 || data_out !== d || corrected_code !== cc ||
          error_pos !== s || error_d !== ed) begin
        n_errors++;
        $display("FAIL %s hold%0d got v=%b r=%b d=%b cc=%b s=%b e=%b exp v=1 r=0 d=%b cc=%b s=%b e=%b",
                 name, i, dout_valid, sin_ready, data_out, corrected_code, error_pos, error_d, d, cc, s, ed);
      end
    end
    sin_valid = 1'b0; sin_sof = 1'b0; sin_bit = 1'b0;
    dout_ready = 1'b1; cnt_clr = clr_hs;
    @(negedge clk);
    dout_ready = 1'b0; cnt_clr = 1'b0;
    if (clr_hs) m_cnt = 0;
    else if (ed && m_cnt < CNT_MAX) m_cnt++;
    n_checks++; if (dout_valid !== 1'b0 || sin_ready !== 1'b1) begin n_errors++; $display("FAIL %s after_hs got v=%b r=%b exp v=0 r=1", name, dout_valid, sin_ready); end
    n_checks++; if (err_count !== CNT_W'(m_cnt)) begin n_errors++; $display("FAIL %s err_count got %0d exp %0d", name, err_count, m_cnt); end
    n_checks++; if (data_out !== d) begin n_errors++; $display("FAIL %s hold_after_hs got %b exp %b", name, data_out, d); end
  endtask

  task automatic test_reset();
    n_checks++;
    if (sin_ready !== 1'b1 || dout_valid !== 1'b0 || data_out !== 4'd0 || corrected_code !== 7'd0 ||
        error_pos !== 3'd0 || error_d !== 1'b0 || frame_err !== 1'b0 || err_count !== '0) begin
      n_errors++;
      $display("FAIL reset got r=%b v=%b d=%b cc=%b s=%b e=%b fe=%b cnt=%0d exp r=1 all else 0",
               sin_ready, dout_valid, data_out, corrected_code, error_pos, error_d, frame_err, err_count);
    end
  endtask

  task automatic test_directed();
    send_code(7'b0101101, 1'b0); expect_result(7'b0101101, 1'b0, 0, 1'b0, "clean_even");
    send_code(7'b0111101, 1'b0); expect_result(7'b0111101, 1'b0, 0, 1'b0, "err_pos5_even");
    send_code(7'b0001011, 1'b1); expect_result(7'b0001011, 1'b1, 0, 1'b0, "clean_odd");
    send_code(7'b0001001, 1'b1); expect_result(7'b0001001, 1'b1, 0, 1'b0, "err_pos2_odd");
  endtask

  task automatic test_abort();
    int base;
    base = fe_cnt;
    drive_beat(1'b1, 1'b1);
    drive_beat(1'b0, 1'b0);
    drive_beat(1'b1, 1'b0);
    drive_beat(1'b1, 1'b0);
    send_code(7'b0101101, 1'b0);
    expect_result(7'b0101101, 1'b0, 0, 1'b0, "abort_frame");
    n_checks++; if (fe_cnt - base != 1) begin n_errors++; $display("FAIL abort frame_err_cycles got %0d exp 1", fe_cnt - base); end
  endtask

  task automatic test_backpressure_stray();
    int base;
    send_code(7'b1010010, 1'b0);
    expect_result(7'b1010010, 1'b0, 5, 1'b0, "backpressure");
    base = fe_cnt;
    drive_beat(1'b1, 1'b0);
    drive_beat(1'b1, 1'b0);
    send_code(7'b0011001, 1'b0);
    expect_result(7'b0011001, 1'b0, 0, 1'b0, "stray_then_frame");
    n_checks++; if (fe_cnt != base) begin n_errors++; $display("FAIL stray frame_err_cycles got %0d exp 0", fe_cnt - base); end
  endtask

  task automatic test_random();
    logic [7:1] c;
    logic       p;
    for (int k = 0; k < 24; k++) begin
      c = 7'($urandom);
      p = 1'($urandom);
      send_code(c, p);
      expect_result(c, p, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  task automatic test_counter();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    m_cnt = 0;
    n_checks++; if (err_count !== '0) begin n_errors++; $display("FAIL cnt_clr got %0d exp 0", err_count); end
    for (int k = 0; k < 4; k++) begin
      send_code(7'b0111101, 1'b0);
      expect_result(7'b0111101, 1'b0, 0, 1'b0, "cnt_err_frame");
    end
    n_checks++; if (err_count !== CNT_W'(CNT_MAX)) begin n_errors++; $display("FAIL cnt_saturate got %0d exp %0d", err_count, CNT_MAX); end
    send_code(7'b0111101, 1'b0);
    expect_result(7'b0111101, 1'b0, 0, 1'b1, "cnt_clr_priority");
  endtask

  task automatic test_reset_mid();
    bit seen;
    drive_beat(1'b1, 1'b1);
    drive_beat(1'b0, 1'b0);
    drive_beat(1'b1, 1'b0);
    drive_beat(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    n_checks++; if (sin_ready !== 1'b1 || dout_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_frame got r=%b v=%b exp r=1 v=0", sin_ready, dout_valid); end
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    n_checks++; if (err_count !== '0) begin n_errors++; $display("FAIL rst_count got %0d exp 0", err_count); end
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (dout_valid !== 1'b0) seen = 1'b1; end
    n_checks++; if (seen) begin n_errors++; $display("FAIL rst_no_output got valid=1 exp 0"); end
    send_code(7'b0111101, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (dout_valid !== 1'b0 || error_d !== 1'b0) begin n_errors++; $display("FAIL rst_mid_out got v=%b e=%b exp 0 0", dout_valid, error_d); end
    @(negedge clk);
    rst = 1'b0;
    send_code(7'b0101101, 1'b0);
    expect_result(7'b0101101, 1'b0, 0, 1'b0, "after_reset");
  endtask

  initial begin
    rst = 1'b1; parity_type = 1'b0; sin_valid = 1'b0; sin_sof = 1'b0; sin_bit = 1'b0;
    dout_ready = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_directed();
    test_abort();
    test_backpressure_stray();
    test_random();
    test_counter();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
